// File: rtl/adc_tx_pkg.sv
// Shared definitions for the ADC sample framer.
//   state_t       : framer FSM states
//   SYNC_BYTE_DEF : default first byte of every frame
//   FRAME_BYTES   : bytes per frame (sync, sample high, sample low)
//   DROP_CNT_W    : width of the saturating drop counter
package adc_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_BYTES   = 3;
  localparam int         DROP_CNT_W    = 8;

endpackage

// File: rtl/adc_tx_framer_sample_fifo.sv
// sample_fifo: single-clock synchronous FIFO.
// Ports:
//   clk_i, reset_ni : clock, async active-low reset
//   push, din       : write request and data (ignored when full)
//   pop, dout       : read request and head-of-queue data (ignored when empty)
//   full, empty     : status
//   level           : current occupancy, 0..DEPTH
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/adc_tx_framer.sv
// adc_tx_framer: buffers 16-bit ADC samples and sends each one as a
// 3-byte frame (SYNC_BYTE, sample[15:8], sample[7:0]) over a
// request/ok/err byte handshake, retrying failed bytes.
// Ports:
//   clk_i, reset_ni               : clock, async active-low reset
//   sample_valid_i, sample_i      : sample strobe and data
//   tx_data_rdy_o, tx_data_o      : byte request pulse and byte
//   tx_ok_i, tx_err_i, busy_i     : handshake responses and interface busy
//   overflow_o, frame_err_o       : sticky error flags
//   drop_count_o                  : saturating drop/abandon count
//   level_o                       : sample FIFO occupancy
//
// state | meaning
// IDLE  | no frame in flight; pops the next sample if one is queued
// ISSUE | waiting for busy_i low to pulse the current byte
// WAIT  | byte requested; waiting for tx_ok_i / tx_err_i
module adc_tx_framer
  import adc_tx_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter int         MAX_RETRY = 3,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    sample_valid_i,
  input  logic [15:0]             sample_i,
  output logic                    tx_data_rdy_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_ok_i,
  input  logic                    tx_err_i,
  input  logic                    busy_i,
  output logic                    overflow_o,
  output logic                    frame_err_o,
  output logic [DROP_CNT_W-1:0]   drop_count_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int         RW       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  state_t            state, state_d;
  logic [15:0]       frame_q;
  logic [1:0]        idx_q;
  logic [RW-1:0]     retry_q;
  logic              pop, adv, retry_inc, retry_clr, abandon;
  logic              fifo_full, fifo_empty, drop_in;
  logic [15:0]       fifo_dout;
  logic [DROP_CNT_W:0] drop_sum;

  sample_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push     (sample_valid_i),
    .din      (sample_i),
    .pop      (pop),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level_o)
  );

  // Full is judged before any same-cycle pop, so a push into a full FIFO
  // is always a drop.
  assign drop_in  = sample_valid_i && fifo_full;
  assign drop_sum = {1'b0, drop_count_o}
                  + {{DROP_CNT_W{1'b0}}, drop_in}
                  + {{DROP_CNT_W{1'b0}}, abandon};

  always_comb begin
    state_d       = state;
    pop           = 1'b0;
    adv           = 1'b0;
    retry_inc     = 1'b0;
    retry_clr     = 1'b0;
    abandon       = 1'b0;
    tx_data_rdy_o = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!busy_i) begin
          tx_data_rdy_o = 1'b1;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        // err wins when ok and err arrive together
        if (tx_err_i) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_inc = 1'b1;
            state_d   = ISSUE;
          end else begin
            abandon = 1'b1;
            state_d = IDLE;
          end
        end else if (tx_ok_i) begin
          retry_clr = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            adv     = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data_o = 8'h00;
    if (state != IDLE) begin
      case (idx_q)
        2'd0:    tx_data_o = SYNC_BYTE;
        2'd1:    tx_data_o = frame_q[15:8];
        default: tx_data_o = frame_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      frame_q      <= '0;
      idx_q        <= '0;
      retry_q      <= '0;
      overflow_o   <= 1'b0;
      frame_err_o  <= 1'b0;
      drop_count_o <= '0;
    end else begin
      state <= state_d;
      if (pop) begin
        frame_q <= fifo_dout;
        idx_q   <= '0;
      end else if (adv) begin
        idx_q <= idx_q + 2'd1;
      end
      if (retry_clr || abandon) retry_q <= '0;
      else if (retry_inc)      retry_q <= retry_q + RW'(1);
      if (drop_in) overflow_o  <= 1'b1;
      if (abandon) frame_err_o <= 1'b1;
      if (drop_sum[DROP_CNT_W]) drop_count_o <= '1;
      else                      drop_count_o <= drop_sum[DROP_CNT_W-1:0];
    end
  end

endmodule
